// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: sequential PC issue, response FIFO, branch redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   occupancy;
    logic [31:0]   br_pc;
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;

    // In-flight requests reserve FIFO slots, so the FIFO can never overflow.
    assign occupancy  = {1'b0, count} + {1'b0, outstanding};
    assign imem_req   = !reset && !br_taken && (occupancy < DEPTH_C);
    assign imem_addr  = fetch_pc;
    assign accept     = imem_req && imem_ready;
    assign resp       = imem_rvalid && (outstanding != '0);
    assign push       = resp && (drop_cnt == '0) && !br_taken;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && !stall && !br_taken;
    assign br_pc      = br_target & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (br_taken) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= br_pc;
                resp_pc  <= br_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop_cnt <= outstanding - CW'(resp);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

    assign pc   = inst_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;
    assign inst = inst_valid ? fifo_inst[rd_ptr] : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - bench for fetch_unit: queue model plus directed timeline checks
module tb_fetch_unit;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] MASK  = 32'hA5A5_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] rdata0 = 32'h0;
    logic [31:0] rdata1 = 32'h0;
    logic        req0, req1, valid0, valid1;
    logic [31:0] addr0, addr1, pc0, pc1, inst0, inst1;

    int n_pass = 0;
    int n_tot  = 0;
    int lat    = 1;
    bit spur   = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem_req(req0), .imem_addr(addr0), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_rdata(rdata0), .pc(pc0), .inst(inst0), .inst_valid(valid0)
    );

    fetch_unit #(.RESET_PC(RPC1), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem_req(req1), .imem_addr(addr1), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_rdata(rdata1), .pc(pc1), .inst(inst1), .inst_valid(valid1)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ MASK;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                         input logic rdy);
        @(negedge clk);
        reset = r; stall = s; br_taken = b; br_target = t; imem_ready = rdy;
    endtask

    // Memory: fixed-latency, in-order; one entry per accepted request, for both DUTs.
    typedef struct { logic [31:0] a0; logic [31:0] a1; int due; } mreq_t;
    mreq_t       mq[$];
    logic [31:0] mf_pc[$];
    logic [31:0] mf_inst[$];
    logic [31:0] m_fpc = 32'h0, m_rpc = 32'h0, off = 32'h0;
    int          m_out = 0, m_drop = 0, cyc = 0;
    bit          chk_en = 1'b0;
    bit          hit, e_valid, e_req, rsp, acc;
    logic [31:0] e_pc, e_inst;

    initial forever begin
        @(negedge clk);
        #1;
        hit = (mq.size() > 0) && (mq[0].due == cyc);
        if (hit) begin
            imem_rvalid = 1'b1; rdata0 = mem(mq[0].a0); rdata1 = mem(mq[0].a1);
        end else begin
            imem_rvalid = spur; rdata0 = 32'hDEAD_BEEF; rdata1 = 32'hDEAD_BEEF;
        end
        #1;
        e_valid = (mf_pc.size() != 0);
        e_pc    = e_valid ? mf_pc[0] : 32'h0;
        e_inst  = e_valid ? mf_inst[0] : NOP;
        e_req   = !reset && !br_taken && ((mf_pc.size() + m_out) < DEPTH);
        if (chk_en) begin
            chk("valid0", valid0, e_valid);
            chk("pc0", pc0, e_pc);
            chk("inst0", inst0, e_inst);
            chk("req0", req0, e_req);
            if (e_req) chk("addr0", addr0, m_fpc);
            chk("valid1", valid1, e_valid);
            chk("pc1", pc1, e_valid ? e_pc + off : 32'h0);
            chk("inst1", inst1, e_valid ? mem(e_pc + off) : NOP);
            chk("req1", req1, e_req);
            if (e_req) chk("addr1", addr1, m_fpc + off);
            chk("inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        end
        acc = req0 && imem_ready;
        if (reset) begin
            mq.delete();
        end else begin
            if (hit) mq.delete(0);
            if (acc) mq.push_back('{addr0, addr1, cyc + lat});
        end
        if (reset) begin
            mf_pc.delete(); mf_inst.delete();
            m_fpc = 32'h0; m_rpc = 32'h0; m_out = 0; m_drop = 0;
            off = RPC1; chk_en = 1'b1;
        end else begin
            rsp = imem_rvalid && (m_out > 0);
            if (br_taken) begin
                mf_pc.delete(); mf_inst.delete();
                m_fpc = br_target & ~32'h3; m_rpc = m_fpc;
                m_drop = m_out - int'(rsp); m_out = m_out - int'(rsp);
                off = 32'h0;
            end else begin
                if (e_valid && !stall) begin
                    mf_pc.delete(0); mf_inst.delete(0);
                end
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        mf_pc.push_back(m_rpc); mf_inst.push_back(rdata0); m_rpc += 32'd4;
                    end
                end
                if (e_req && imem_ready) m_fpc += 32'd4;
                m_out = m_out + int'(e_req && imem_ready) - int'(rsp);
            end
        end
        cyc++;
    end

    initial begin
        // Sequential fetch, 1-cycle memory
        drive(1, 0, 0, 0, 1); drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1); #3;
        chk("seq_idle_valid", valid0, 0); chk("seq_first_req", req0, 1); chk("seq_first_addr", addr0, 0);
        chk("seq_idle_inst", inst0, NOP);
        drive(0, 0, 0, 0, 1); #3; chk("seq_lat_valid", valid0, 0);
        drive(0, 0, 0, 0, 1); #3;
        chk("seq_first_valid", valid0, 1); chk("seq_pc0", pc0, 0); chk("seq_inst0", inst0, 32'hA5A5_0000);
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 1); #3;
            chk("seq_pc", pc0, 32'(4 * i)); chk("seq_inst", inst0, 32'(4 * i) ^ MASK);
        end
        // Stall 6 cycles with head at 0x10; a stray rvalid arrives while nothing is outstanding
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 0, 1); spur = (i == 4);
            #3; chk("stall_pc", pc0, 32'h10); chk("stall_valid", valid0, 1);
            if (i == 0) chk("stall_req_on", req0, 1);
            if (i >= 2) chk("stall_req_off", req0, 0);
        end
        spur = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1); #3; chk("release_pc", pc0, 32'h10 + 32'(4 * i));
            if (i == 0) chk("release_req_full", req0, 0);
        end
        // Memory not ready for 5 cycles
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0); #3; chk("nrdy_req", req0, 1); chk("nrdy_addr", addr0, 32'h2C);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 1); #3;
            if (i == 2) chk("resume_pc", pc0, 32'h2C);
            if (i == 3) chk("resume_pc_next", pc0, 32'h30);
        end
        // Redirect with three in flight, 3-cycle memory
        lat = 3;
        drive(1, 0, 0, 0, 1); drive(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'h0000_0103, 1); #3; chk("br_req_off", req0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1); #3; chk("br_drop_valid", valid0, 0);
            if (i == 0) begin chk("br_addr", addr0, 32'h100); chk("br_req", req0, 1); end
        end
        drive(0, 0, 0, 0, 1); #3;
        chk("br_first_valid", valid0, 1); chk("br_first_pc", pc0, 32'h100); chk("br_first_inst", inst0, 32'hA5A5_0100);
        drive(0, 0, 0, 0, 1); #3; chk("br_second_pc", pc0, 32'h104);
        // Fill the FIFO under stall, then redirect while still stalled
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 1);
        #3; chk("full_valid", valid0, 1); chk("full_req", req0, 0); chk("full_pc", pc0, 32'h108);
        drive(0, 1, 1, 32'h200, 1); #3; chk("brstall_req", req0, 0);
        drive(0, 1, 0, 0, 1); #3;
        chk("brstall_flush", valid0, 0); chk("brstall_addr", addr0, 32'h200); chk("brstall_req_on", req0, 1);
        drive(0, 0, 1, 32'h300, 1);
        drive(0, 0, 1, 32'h404, 1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1); #3;
            if (i == 0) chk("brbr_addr", addr0, 32'h404);
            if (i < 4) chk("brbr_valid", valid0, 0);
            if (i == 4) begin chk("brbr_pc", pc0, 32'h404); chk("brbr_inst", inst0, 32'hA5A5_0404); end
        end
        // Wrap-around on the second instance, then a mid-stream reset
        lat = 1;
        drive(1, 0, 0, 0, 1); drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1); #3; chk("wrap_addr", addr1, RPC1); chk("wrap_req", req1, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1); #3; chk("wrap_pc0", pc1, 32'hFFFF_FFF8); chk("wrap_inst0", inst1, 32'h5A5A_FFF8);
        drive(0, 0, 0, 0, 1); #3; chk("wrap_pc1", pc1, 32'hFFFF_FFFC); chk("wrap_inst1", inst1, 32'h5A5A_FFFC);
        drive(0, 0, 0, 0, 1); #3; chk("wrap_pc2", pc1, 32'h0000_0000); chk("wrap_inst2", inst1, 32'hA5A5_0000);
        drive(0, 0, 0, 0, 1); #3; chk("wrap_pc3", pc1, 32'h0000_0004);
        drive(1, 0, 0, 0, 1); #3; chk("rst_req_forced", req1, 0);
        drive(0, 0, 0, 0, 1); #3; chk("rst_cleared", valid1, 0); chk("rst_addr", addr1, RPC1);
        drive(0, 0, 0, 0, 1); #3; chk("rst_lat", valid1, 0);
        drive(0, 0, 0, 0, 1); #3; chk("rst_restart_pc", pc1, RPC1); chk("rst_restart_valid", valid1, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the IF/ID pipeline register and drives its `pc`/`inst` inputs.
- Generates sequential fetch addresses and issues them to instruction memory over a ready/valid request interface with in-order variable-latency responses.
- Buffers returned instructions in a small FIFO and presents the head instruction to decode; honours `stall`.
- On `br_taken` it redirects to `br_target`, flushes the FIFO and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 4, FIFO entries and also the maximum of (FIFO occupancy + outstanding requests); power of 2, ≥2.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept this cycle; hold the head entry.
- br_taken  input  1  redirect fetch this cycle.
- br_target  input  32  redirect address; bits [1:0] are forced to 0 internally.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (= fetch_pc).
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid; responses return in request order.
- imem_rdata  input  32  instruction word.
- pc  output  32  PC of the head instruction to IF/ID.
- inst  output  32  head instruction to IF/ID.
- inst_valid  output  1  head entry valid.

Behaviour:
- State:
  - fetch_pc[31:0] and resp_pc[31:0] (PC of the next expected kept response).
  - FIFO of {pc, inst} with DEPTH entries plus count.
  - outstanding and drop_cnt counters, each $clog2(DEPTH+1) bits wide.
- Reset (synchronous, checked at posedge):
  - fetch_pc = resp_pc = RESET_PC; FIFO count = 0; outstanding = 0; drop_cnt = 0.
  - imem_req is forced to 0 while reset is high.
  - Responses arriving after reset are ignored because outstanding = 0; memory shares the same reset.
- Request issue:
  - imem_req = !reset & !br_taken & (count + outstanding < DEPTH).
  - Accept occurs when imem_req & imem_ready. On accept: fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and outstanding += 1.
  - imem_addr holds stable while imem_req=1 and imem_ready=0.
- Response handling:
  - Each imem_rvalid with outstanding > 0 decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise push {resp_pc, imem_rdata} and set resp_pc += 4.
  - imem_rvalid when outstanding = 0 is ignored; no counter underflows.
  - Issue and response in the same cycle leave outstanding unchanged.
- Output (combinational from registered FIFO head):
  - inst_valid = (count != 0).
  - When count = 0: pc = 0 and inst = 32'h0000_0013 (NOP).
  - Pop when inst_valid & !stall & !br_taken.
  - Push and pop in the same cycle leave count unchanged.
  - The FIFO never overflows, guaranteed by the issue rule.
- Latency:
  - With imem_ready=1 and 1-cycle memory: address issued at cycle N, data in FIFO at N+2 (registered at N+1 edge), presented at N+2.
  - Steady state is one instruction per cycle, no bubbles.
- Redirect (br_taken=1, priority over stall and pop):
  - Next state: count = 0, fetch_pc = resp_pc = {br_target[31:2], 2'b00}, no request this cycle.
  - drop_cnt = outstanding - (imem_rvalid & outstanding != 0 ? 1 : 0), i.e. every remaining in-flight response is discarded.
  - A response arriving in the redirect cycle is discarded and not pushed.
  - br_taken on consecutive cycles: the last target wins; drop_cnt recomputed each cycle from outstanding.
  - New requests may issue the cycle after redirect, subject to count + outstanding < DEPTH (dropped requests still count).
- Reset mid-operation overrides redirect, stall and all responses.

Test Plan:
- Sequential fetch: reset, RESET_PC=0, imem_ready=1, 1-cycle memory returning addr^32'hA5A5_0000 -> inst_valid first high 2 cycles after reset release; pc 0x0, 0x4, 0x8, … every cycle; inst matches; never more than 4 requests outstanding.
- Stall backpressure: assert stall for 6 cycles mid-stream at pc=0x10 -> pc/inst held at 0x10; imem_req drops once count+outstanding=4; after release the output sequence continues 0x10, 0x14, … with no loss or duplication.
- Redirect with in-flight responses: 3-cycle memory, 3 outstanding, br_taken with br_target=0x0000_0103 -> effective target 0x100; next 3 responses dropped; first inst_valid shows pc=0x100, inst=mem[0x100]; no stale PCs appear.
- br_taken and stall together with a full FIFO -> FIFO flushed, inst_valid=0 next cycle, fetch_pc=br_target; stall has no effect on the redirect.
- Memory not ready: imem_ready=0 for 5 cycles -> imem_req stays 1, imem_addr constant, outstanding unchanged; fetching resumes on ready.
- Wrap-around: RESET_PC=32'hFFFF_FFF8 -> output pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004; a reset asserted mid-stream then clears inst_valid and restarts at RESET_PC.
